ps2_kbd_fifo: RTL
=================

Name: ps2_kbd_fifo

Overview:
Receive buffer directly downstream of the PS/2 keyboard decoder. Accepts one-cycle-valid ASCII bytes from the decoder and stores them in a small circular FIFO. Presents them to the 6502 bus as a two-register peripheral (status/control, data), so fast typing is not lost between CPU polls. Adds sticky overflow reporting, a flush control and an optional level interrupt.

Parameters:
AW, 4, FIFO address width; depth = 2**AW entries (16 by default); legal range 2..8
DW, 8, data width of each entry (ASCII byte)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
cs  input  1  chip select from bus decoder
we  input  1  write enable (1 = write, 0 = read)
addr  input  1  register select: 0 = status/control, 1 = data
din  input  8  bus write data
dout  output  8  bus read data, registered
wr_valid  input  1  decoder output valid, 1-cycle pulse
wr_data  input  DW  decoded ASCII byte, qualified by wr_valid
irq  output  1  interrupt request, active-high level

Behaviour:
- Storage
  - 2**AW x DW circular buffer.
  - Write pointer and read pointer are AW bits each and wrap modulo depth.
  - Occupancy counter is AW+1 bits, range 0..2**AW.
  - empty = (count == 0); full = (count == 2**AW).
- Reset (rst_n low, asynchronous)
  - Pointers, count, ovfl, irq_en, dout and irq all go to 0.
  - Storage contents are don't-care.
  - Reset asserted mid-access aborts the access; nothing is popped.
- Push
  - Occurs when wr_valid=1 and not full: mem[wp] <= wr_data, wp+1, count+1.
- Pop
  - Occurs on a bus read of addr=1 (cs & !we & addr) when not empty: rp+1, count-1.
  - dout <= mem[rp] on the next clock, i.e. 1-cycle read latency.
  - Read of addr=1 when empty: dout <= 8'h00; pointers and count unchanged.
- Status read (cs & !we & !addr)
  - dout <= {4'b0, irq_en, ovfl, full, !empty}, registered.
  - No side effects.
- Control write (cs & we & !addr)
  - din[0] = flush: one-shot, not stored. Sets wp=rp=count=0 and clears ovfl.
  - din[1] = irq_en: stored.
- Data write (cs & we & addr): ignored.
- dout holds its last value whenever no read is in progress.
- Simultaneous events
  - Push and pop in the same cycle, not full and not empty: both occur, count unchanged.
  - Push and pop in the same cycle while full: both occur, the new byte is stored, ovfl is not set.
  - Push and pop in the same cycle while empty: push only; the read returns 8'h00.
  - Push while full with no pop: byte dropped, ovfl <= 1 (sticky until flush or reset).
  - Flush and push in the same cycle: flush wins, byte dropped, ovfl cleared.
- Pointer wrap
  - After 2**AW pushes and pops, wp/rp wrap to 0.
  - Data ordering is preserved across the wrap.

Optional Feature:
PS2_KBD_FIFO_IRQ_EN
- Defined: irq is registered, irq <= irq_en & !empty.
  - irq asserts the cycle after the first push with irq_en=1.
  - irq deasserts the cycle after the pop that empties the FIFO, or after a flush.
- Undefined: irq tied 0, irq_en register omitted, status bit 3 reads 0, din[1] ignored.

Decomposition:
- Shared package ps2_pkg holds:
  - register offsets REG_STAT=0, REG_DATA=1
  - status bit indices ST_NEMPTY=0, ST_FULL=1, ST_OVFL=2, ST_IRQEN=3
  - control bit indices CR_FLUSH=0, CR_IRQEN=1
  - EMPTY_READ=8'h00
- One sub-module: ps2_fifo_mem.
  - Simple dual-port array: synchronous write, registered read.
  - Infers as iCE40 EBR (or LUT RAM for small AW).
  - Push/pop control, count, flags and bus logic stay in the top module.

Test Plan:
- Reset, then read status -> dout=8'h00 on the cycle after the read; read data when empty -> 8'h00; irq=0.
- Push 'A','B','C' (8'h41,42,43) -> status=8'h01; three data reads return 41, 42, 43 in order; status then reads 8'h00.
- Push 17 bytes 8'h30..8'h40 with AW=4 and no reads -> status=8'h07 (ovfl, full, nempty); reads return 30..3F; byte 40 is lost.
- Full FIFO, push 8'h55 in the same cycle as a data read -> read returns the oldest byte; ovfl stays 0; after draining, the last byte read is 8'h55.
- Control write 8'h01 with 5 entries and ovfl set -> status=8'h00 next cycle; a wr_valid pulse in the flush cycle is dropped.
- With PS2_KBD_FIFO_IRQ_EN: write 8'h02, push 8'h61 -> irq=1 one cycle later; data read -> irq=0 one cycle after the pop; status=8'h08. Assert rst_n low mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard receive FIFO: bus register
// offsets, status/control bit positions, the value returned by a read of an
// empty FIFO, and a small bus-cycle decoder used by the top level.
// ---------------------------------------------------------------------------
package ps2_pkg;

  // Register offsets (addr input)
  localparam logic REG_STAT = 1'b0;
  localparam logic REG_DATA = 1'b1;

  // Status register bit indices
  localparam int ST_NEMPTY = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_OVFL   = 2;
  localparam int ST_IRQEN  = 3;

  // Control register bit indices
  localparam int CR_FLUSH = 0;
  localparam int CR_IRQEN = 1;

  localparam logic [7:0] EMPTY_READ = 8'h00;

  // Kind of bus access presented this cycle. Data-register writes have no
  // effect and decode to idle.
  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_RD_STAT,
    BUS_RD_DATA,
    BUS_WR_CTRL
  } bus_op_e;

  function automatic bus_op_e decode_bus(input logic cs, input logic we,
                                         input logic addr);
    if (!cs) return BUS_IDLE;
    if (!we) return (addr == REG_DATA) ? BUS_RD_DATA : BUS_RD_STAT;
    return (addr == REG_STAT) ? BUS_WR_CTRL : BUS_IDLE;
  endfunction

endpackage

// File: rtl/ps2_fifo_mem.sv
// ---------------------------------------------------------------------------
// ps2_fifo_mem
// Simple dual-port storage for the keyboard FIFO: synchronous write port,
// registered read port with read enable (maps onto an iCE40 EBR, or LUT RAM
// for small AW). Read and write of the same address in one cycle return the
// old contents.
// Ports:
//   clk            clock
//   we/waddr/wdata write port
//   re/raddr       read request; rdata updates on the following edge only
//   rdata          registered read data (holds between reads)
// ---------------------------------------------------------------------------
module ps2_fifo_mem #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  // NOTE: the array and its output register are deliberately not reset; a
  // reset would prevent block-RAM inference, and the contents are
  // don't-care until written.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ps2_kbd_fifo.sv
// ---------------------------------------------------------------------------
// ps2_kbd_fifo
// Receive FIFO between the PS/2 keyboard decoder and the 6502 bus. Decoded
// bytes are pushed on wr_valid; the CPU reads them through a two-register
// peripheral (0 = status/control, 1 = data). Overflow is sticky until a
// flush (control bit 0) or reset.
// Optional feature macro: PS2_KBD_FIFO_IRQ_EN -- adds the irq_en control bit
// and a registered level interrupt irq = irq_en & !empty. Without it irq is
// tied low and status bit 3 reads 0.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   cs, we, addr, din  bus access (we=1 write, addr selects register)
//   dout               bus read data, one-cycle read latency, holds otherwise
//   wr_valid, wr_data  decoder byte stream (1-cycle valid pulses)
//   irq                active-high level interrupt
// ---------------------------------------------------------------------------
module ps2_kbd_fifo
  import ps2_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic          we,
  input  logic          addr,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          irq
);

  localparam int            DEPTH_I = 1 << AW;
  localparam logic [AW:0]   DEPTH   = DEPTH_I[AW:0];
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   count_q, count_d;
  logic          ovfl_q, ovfl_d;
  logic [7:0]    dout_q, dout_d;
  logic          mem_pend_q, mem_pend_d;   // last access popped; dout comes from RAM
  logic [DW-1:0] mem_rdata;
  logic [7:0]    mem_rdata8;
  logic          empty, full, flush, push, pop;
  logic          irq_en_bit;
  logic          unused_din;
  logic [7:0]    status;
  bus_op_e       bus_op;

  assign bus_op = decode_bus(cs, we, addr);
  assign empty  = (count_q == '0);
  assign full   = (count_q == DEPTH);
  assign flush  = (bus_op == BUS_WR_CTRL) && din[CR_FLUSH];
  assign pop    = (bus_op == BUS_RD_DATA) && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push   = wr_valid && !flush && (!full || pop);

  ps2_fifo_mem #(.AW(AW), .DW(DW)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wp_q),
    .wdata (wr_data),
    .re    (pop),
    .raddr (rp_q),
    .rdata (mem_rdata)
  );

  assign mem_rdata8 = 8'(mem_rdata);

  always_comb begin
    status             = '0;
    status[ST_NEMPTY]  = !empty;
    status[ST_FULL]    = full;
    status[ST_OVFL]    = ovfl_q;
    status[ST_IRQEN]   = irq_en_bit;
  end

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    ovfl_d     = ovfl_q;
    dout_d     = dout;
    mem_pend_d = 1'b0;

    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
      ovfl_d  = 1'b0;
    end else begin
      if (push) wp_d = wp_q + PTR_ONE;
      if (pop)  rp_d = rp_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (wr_valid && full && !pop) ovfl_d = 1'b1;
    end

    // Popped data appears straight from the RAM output register next
    // cycle; it is copied into dout_q afterwards so it keeps holding.
    case (bus_op)
      BUS_RD_STAT: dout_d = status;
      BUS_RD_DATA: begin
        if (pop) mem_pend_d = 1'b1;
        else     dout_d     = EMPTY_READ;
      end
      default: ;
    endcase
  end

  assign dout = mem_pend_q ? mem_rdata8 : dout_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      ovfl_q     <= 1'b0;
      dout_q     <= '0;
      mem_pend_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      ovfl_q     <= ovfl_d;
      dout_q     <= dout_d;
      mem_pend_q <= mem_pend_d;
    end
  end

`ifdef PS2_KBD_FIFO_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q, irq_d;

  always_comb begin
    irq_en_d = irq_en_q;
    if (bus_op == BUS_WR_CTRL) irq_en_d = din[CR_IRQEN];
    irq_d = irq_en_q && !empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq        = irq_q;
  assign irq_en_bit = irq_en_q;
  assign unused_din = ^din[7:2];
`else
  assign irq        = 1'b0;
  assign irq_en_bit = 1'b0;
  assign unused_din = ^{din[7:2], din[CR_IRQEN]};
`endif

endmodule
